// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bundles the receiver-side push signals and the CPU-side
// pop/status signals of the receive FIFO.
// master = receiver/CPU side that drives strobes and pops; slave = the FIFO.
interface uart_rx_fifo_if #(
  parameter int AW = 4,
  parameter int DW = 8
);
  logic [DW-1:0] rx_data;
  logic          rx_strobe;
  logic          rd_en;
  logic          ovr_clr;
  logic [DW-1:0] dout;
  logic          empty;
  logic          full;
  logic [AW:0]   level;
  logic          overrun;
  logic          irq_thresh;

  modport master (
    output rx_data, rx_strobe, rd_en, ovr_clr,
    input  dout, empty, full, level, overrun, irq_thresh
  );

  modport slave (
    input  rx_data, rx_strobe, rd_en, ovr_clr,
    output dout, empty, full, level, overrun, irq_thresh
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: circular receive FIFO behind the UART receiver.
// Each rising edge of rx_strobe pushes rx_data; the head entry is presented
// first-word-fall-through on dout (0 when empty). A push while full with no
// simultaneous pop is dropped and sets the sticky overrun flag.
// Optional feature macro UART_RX_THRESH_EN: when defined, irq_thresh is a
// registered "level >= THRESH" flag; when undefined, irq_thresh = !empty.
module uart_rx_fifo #(
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int THRESH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_fifo_if.slave  bus
);
  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_strobe_q;
  logic          r_overrun;

  logic w_push;
  logic w_pop;
  logic w_wr;
  logic w_empty;
  logic w_full;

  // Edge detect on the receiver strobe plus accept/pop qualification.
  always_comb begin
    w_empty = (r_level == '0);
    w_full  = (r_level == LVL_FULL);
    w_push  = bus.rx_strobe & ~r_strobe_q;
    w_pop   = bus.rd_en & ~w_empty;
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    w_wr    = w_push & (~w_full | w_pop);
  end

  // Strobe history register for the rising-edge push detect.
  always_ff @(posedge clk) begin
    if (rst) r_strobe_q <= 1'b0;
    else     r_strobe_q <= bus.rx_strobe;
  end

  // Storage array; deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.rx_data;
  end

  // Pointer and fill-level bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky overrun; a new drop wins over a coincident clear.
  always_ff @(posedge clk) begin
    if (rst)                          r_overrun <= 1'b0;
    else if (w_push & w_full & ~w_pop) r_overrun <= 1'b1;
    else if (bus.ovr_clr)             r_overrun <= 1'b0;
  end

`ifdef UART_RX_THRESH_EN
  localparam logic [AW:0] THRESH_LVL = (AW+1)'(THRESH);
  logic r_irq;

  // Threshold flag follows the registered level one cycle later.
  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= (r_level >= THRESH_LVL);
  end

  assign bus.irq_thresh = r_irq;
`else
  // Without the threshold feature the interrupt is plain byte-ready.
  assign bus.irq_thresh = ~w_empty;

  // THRESH only matters with the feature on; an out-of-range value
  // elaborates this empty marker block so it stays visible in the hierarchy.
  if (THRESH < 1 || THRESH > DEPTH) begin : g_thresh_out_of_range
  end
`endif

  assign bus.dout    = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.empty   = w_empty;
  assign bus.full    = w_full;
  assign bus.level   = r_level;
  assign bus.overrun = r_overrun;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo (AW=4, DW=8).
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] q[$];
  logic [7:0] got;

  uart_rx_fifo_if #(.AW(4), .DW(8)) bus ();

  uart_rx_fifo #(.AW(4), .DW(8), .THRESH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe followed by one low cycle so the next push is a new edge.
  task automatic push(input logic [7:0] d);
    bus.rx_data   = d;
    bus.rx_strobe = 1'b1;
    tick();
    bus.rx_strobe = 1'b0;
    tick();
  endtask

  // Pop one byte; dout is the head before the popping edge.
  task automatic pop(output logic [7:0] d);
    d = bus.dout;
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic push_q(input logic [7:0] d);
    push(d);
    q.push_back(d);
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    logic [7:0] d;
    e = q.pop_front();
    pop(d);
    chk(tag, {24'd0, d}, {24'd0, e});
  endtask

  initial begin
    bus.rx_data   = 8'h00;
    bus.rx_strobe = 1'b0;
    bus.rd_en     = 1'b0;
    bus.ovr_clr   = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_level",   {27'd0, bus.level}, 32'd0);
    chk("rst_empty",   {31'd0, bus.empty}, 32'd1);
    chk("rst_full",    {31'd0, bus.full}, 32'd0);
    chk("rst_overrun", {31'd0, bus.overrun}, 32'd0);
    chk("rst_irq",     {31'd0, bus.irq_thresh}, 32'd0);
    chk("rst_dout",    {24'd0, bus.dout}, 32'd0);

    // rd_en while empty is ignored
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("pop_empty_level", {27'd0, bus.level}, 32'd0);

    // single push, visible the next cycle
    bus.rx_data   = 8'hA5;
    bus.rx_strobe = 1'b1;
    tick();
    bus.rx_strobe = 1'b0;
    chk("t1_empty", {31'd0, bus.empty}, 32'd0);
    chk("t1_dout",  {24'd0, bus.dout}, 32'h A5);
    chk("t1_level", {27'd0, bus.level}, 32'd1);
`ifndef UART_RX_THRESH_EN
    chk("t1_irq_byte_ready", {31'd0, bus.irq_thresh}, 32'd1);
`endif
    tick();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    chk("t1_pop_empty", {31'd0, bus.empty}, 32'd1);
    chk("t1_pop_dout",  {24'd0, bus.dout}, 32'd0);
`ifndef UART_RX_THRESH_EN
    chk("t1_irq_clear", {31'd0, bus.irq_thresh}, 32'd0);
`endif

    // strobe held high 5 cycles gives exactly one push
    bus.rx_data   = 8'h3C;
    bus.rx_strobe = 1'b1;
    repeat (5) tick();
    bus.rx_strobe = 1'b0;
    tick();
    chk("t2_level", {27'd0, bus.level}, 32'd1);
    pop(got);
    chk("t2_data", {24'd0, got}, 32'h3C);
    chk("t2_empty", {31'd0, bus.empty}, 32'd1);

    // fill to full, drain in order
    for (int i = 0; i < 16; i++) push_q(8'(i));
    chk("t3_full",  {31'd0, bus.full}, 32'd1);
    chk("t3_level", {27'd0, bus.level}, 32'd16);
    for (int i = 0; i < 16; i++) pop_chk("t3_order");
    chk("t3_drained", {31'd0, bus.empty}, 32'd1);

    // 20 bytes across pointer wrap, interleaved
    for (int i = 0; i < 12; i++) push_q(8'h40 + 8'(i));
    chk("t3_wrap_lvl12", {27'd0, bus.level}, 32'd12);
    for (int i = 0; i < 6; i++) pop_chk("t3_wrap_a");
    for (int i = 12; i < 20; i++) push_q(8'h40 + 8'(i));
    chk("t3_wrap_lvl14", {27'd0, bus.level}, 32'd14);
    for (int i = 0; i < 14; i++) pop_chk("t3_wrap_b");
    chk("t3_wrap_empty", {31'd0, bus.empty}, 32'd1);

    // overrun: push while full is dropped
    for (int i = 0; i < 16; i++) push_q(8'h80 + 8'(i));
    push(8'hEE);
    chk("t4_overrun", {31'd0, bus.overrun}, 32'd1);
    chk("t4_level",   {27'd0, bus.level}, 32'd16);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    chk("t4_clr", {31'd0, bus.overrun}, 32'd0);
    bus.rx_data   = 8'hEF;
    bus.rx_strobe = 1'b1;
    bus.ovr_clr   = 1'b1;
    tick();
    bus.rx_strobe = 1'b0;
    bus.ovr_clr   = 1'b0;
    chk("t4_set_wins", {31'd0, bus.overrun}, 32'd1);
    tick();
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    chk("t4_clr2", {31'd0, bus.overrun}, 32'd0);
    for (int i = 0; i < 16; i++) pop_chk("t4_no_ee");
    chk("t4_empty", {31'd0, bus.empty}, 32'd1);

    // simultaneous push+pop while full
    for (int i = 0; i < 16; i++) push_q(8'h60 + 8'(i));
    got = bus.dout;
    bus.rx_data   = 8'h77;
    bus.rx_strobe = 1'b1;
    bus.rd_en     = 1'b1;
    tick();
    bus.rx_strobe = 1'b0;
    bus.rd_en     = 1'b0;
    chk("t5_head", {24'd0, got}, {24'd0, q.pop_front()});
    q.push_back(8'h77);
    chk("t5_level",   {27'd0, bus.level}, 32'd16);
    chk("t5_overrun", {31'd0, bus.overrun}, 32'd0);
    tick();
    for (int i = 0; i < 15; i++) pop_chk("t5_order");
    pop(got);
    chk("t5_last77", {24'd0, got}, 32'h77);
    chk("t5_empty", {31'd0, bus.empty}, 32'd1);

`ifdef UART_RX_THRESH_EN
    // threshold: irq one cycle after level reaches 8
    for (int i = 0; i < 7; i++) push(8'h10 + 8'(i));
    chk("t6_irq_below", {31'd0, bus.irq_thresh}, 32'd0);
    bus.rx_data   = 8'h17;
    bus.rx_strobe = 1'b1;
    tick();
    bus.rx_strobe = 1'b0;
    chk("t6_irq_lag", {31'd0, bus.irq_thresh}, 32'd0);
    tick();
    chk("t6_irq_set", {31'd0, bus.irq_thresh}, 32'd1);
    pop(got);
    chk("t6_irq_hold", {31'd0, bus.irq_thresh}, 32'd1);
    tick();
    chk("t6_irq_clr", {31'd0, bus.irq_thresh}, 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
`endif

    // reset mid-operation with level 5
    for (int i = 0; i < 5; i++) push(8'h20 + 8'(i));
    chk("t6_pre_level", {27'd0, bus.level}, 32'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_level",   {27'd0, bus.level}, 32'd0);
    chk("t6_rst_empty",   {31'd0, bus.empty}, 32'd1);
    chk("t6_rst_overrun", {31'd0, bus.overrun}, 32'd0);
    chk("t6_rst_irq",     {31'd0, bus.irq_thresh}, 32'd0);
    push(8'h5A);
    chk("t6_post_dout",  {24'd0, bus.dout}, 32'h5A);
    chk("t6_post_level", {27'd0, bus.level}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
